// File: rtl/fpu_rr_scheduler.sv
// fpu_rr_scheduler
// Shares a single ieee754_alu between NREQ requesters. Requests are granted
// one at a time in round-robin order. The granted op and operands are held
// on the ALU for the op's latency, then the result and compare flags are
// captured and returned to the winner over a valid/ack handshake.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid[NREQ]          per-requester request strobe
//   req_op[3*NREQ]           op of requester i at [3i+2:3i]
//   req_a/req_b[32*NREQ]     operands of requester i at [32i+31:32i]
//   req_ready[NREQ]          one-cycle one-hot accept pulse
//   resp_valid[NREQ]         one-hot result-pending indication
//   resp_ack[NREQ]           requester consumes its result
//   resp_data, resp_great/less/equal, resp_err   returned result
//   alu_op/alu_a/alu_b       drive the shared ALU
//   alu_out, alu_great/less/equal               ALU result inputs
//   busy                     high whenever the scheduler is not idle
module fpu_rr_scheduler #(
    parameter int NREQ    = 4,
    parameter int LAT_ADD = 3,
    parameter int LAT_MUL = 4,
    parameter int LAT_DIV = 8,
    parameter int LAT_CMP = 2,
    parameter int CW      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [3*NREQ-1:0]    req_op,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ack,
    output logic [31:0]          resp_data,
    output logic                 resp_great,
    output logic                 resp_less,
    output logic                 resp_equal,
    output logic                 resp_err,
    output logic [2:0]           alu_op,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    input  logic [31:0]          alu_out,
    input  logic                 alu_great,
    input  logic                 alu_less,
    input  logic                 alu_equal,
    output logic                 busy
);

    localparam int IW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   gnt;
    logic [CW-1:0]   cnt;

    logic [2:0]      op_arr [NREQ];
    logic [31:0]     a_arr  [NREQ];
    logic [31:0]     b_arr  [NREQ];

    logic            hit;
    logic [IW-1:0]   pick;
    logic [IW:0]     sum;

    // Unpack the flat request buses so the winner can be selected by index.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            op_arr[i] = req_op[3*i +: 3];
            a_arr[i]  = req_a[32*i +: 32];
            b_arr[i]  = req_b[32*i +: 32];
        end
    end

    // Round-robin search: first valid requester at or after rr_ptr, wrapping
    // modulo NREQ. rr_ptr and k are both below NREQ, so one subtraction is
    // enough to bring the sum back into range.
    always_comb begin
        hit  = 1'b0;
        pick = '0;
        sum  = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            if (!hit && req_valid[sum[IW-1:0]]) begin
                hit  = 1'b1;
                pick = sum[IW-1:0];
            end
        end
    end

    function automatic logic [CW-1:0] lat_m1(input logic [2:0] op);
        case (op)
            3'b000, 3'b001: lat_m1 = CW'(LAT_ADD - 1);
            3'b010:         lat_m1 = CW'(LAT_MUL - 1);
            3'b011:         lat_m1 = CW'(LAT_DIV - 1);
            default:        lat_m1 = CW'(LAT_CMP - 1);
        endcase
    endfunction

    assign busy = (state != IDLE);

    // Scheduler FSM. The ALU operand registers change only on a grant, so the
    // ALU sees stable inputs through ISSUE, WAIT and RESP. Compare flags are
    // only meaningful for op 100; for arithmetic ops the ALU may drive junk on
    // them, so they are forced to zero at capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            gnt        <= '0;
            cnt        <= '0;
            req_ready  <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            resp_great <= 1'b0;
            resp_less  <= 1'b0;
            resp_equal <= 1'b0;
            resp_err   <= 1'b0;
            alu_op     <= 3'b000;
            alu_a      <= '0;
            alu_b      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= '0;
                    if (hit) begin
                        alu_op    <= op_arr[pick];
                        alu_a     <= a_arr[pick];
                        alu_b     <= b_arr[pick];
                        req_ready <= ONE << pick;
                        gnt       <= pick;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    req_ready <= '0;
                    if (alu_op <= 3'b100) begin
                        cnt   <= lat_m1(alu_op);
                        state <= WAIT;
                    end else begin
                        resp_data  <= '0;
                        resp_great <= 1'b0;
                        resp_less  <= 1'b0;
                        resp_equal <= 1'b0;
                        resp_err   <= 1'b1;
                        resp_valid <= ONE << gnt;
                        state      <= RESP;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        resp_data <= alu_out;
                        if (alu_op == 3'b100) begin
                            resp_great <= alu_great;
                            resp_less  <= alu_less;
                            resp_equal <= alu_equal;
                        end else begin
                            resp_great <= 1'b0;
                            resp_less  <= 1'b0;
                            resp_equal <= 1'b0;
                        end
                        resp_err   <= 1'b0;
                        resp_valid <= ONE << gnt;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    // Only the winner's ack bit matters; the pointer moves past
                    // the winner so it competes again at lowest priority.
                    if (resp_ack[gnt]) begin
                        resp_valid <= '0;
                        resp_err   <= 1'b0;
                        rr_ptr     <= (gnt == IW'(NREQ - 1)) ? '0 : gnt + IW'(1);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
